// File: rtl/io_hub_pkg.sv
// -----------------------------------------------------------------------------
// io_hub_pkg
// Shared definitions for the port-mapped I/O hub:
//   - offsets of the four hub registers relative to HUB_BASE
//   - interrupt FSM state encoding
//   - clog2 helper for elaboration-time widths
// -----------------------------------------------------------------------------
package io_hub_pkg;

    // Hub register offsets from HUB_BASE
    localparam logic [1:0] HUB_PENDING = 2'd0;  // RO, zero-extended pending bits
    localparam logic [1:0] HUB_MASK    = 2'd1;  // RW, 1 = channel enabled
    localparam logic [1:0] HUB_VECTOR  = 2'd2;  // RO, {valid, ..., channel index}
    localparam logic [1:0] HUB_CLEAR   = 2'd3;  // WO, write-1-to-clear pending
    localparam int         HUB_NREGS   = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_HOLDOFF = 2'd2
    } irq_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_port_hub_irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Interrupt controller for io_port_hub: rising-edge capture of the channel
// requests into PENDING, MASK register, lowest-index priority encoder and the
// IDLE/ASSERT/HOLDOFF request FSM with acknowledge handshake.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   ch_irq          level requests from the channels
//   mask_we/_wdata  MASK register write (from hub decode)
//   clr_we/_wdata   write-1-to-clear of PENDING (from hub decode)
//   interrupt_ack   acknowledge from the micro
//   pending, mask   register contents for the read mux
//   vector          VECTOR register: bit DW-1 = valid, low bits = channel
//   interrupt       request to the micro
// -----------------------------------------------------------------------------
module irq_arbiter
    import io_hub_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] ch_irq,
    input  logic            mask_we,
    input  logic [N_CH-1:0] mask_wdata,
    input  logic            clr_we,
    input  logic [N_CH-1:0] clr_wdata,
    input  logic            interrupt_ack,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] mask,
    output logic [DW-1:0]   vector,
    output logic            interrupt
);

    localparam int IW = (clog2(N_CH) > 0) ? clog2(N_CH) : 1;

    irq_state_t      state, state_nxt;
    logic [N_CH-1:0] irq_prev;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] w1c;
    logic [N_CH-1:0] mask_nxt;
    logic [N_CH-1:0] vec_onehot;
    logic [N_CH-1:0] ack_bit;
    logic [N_CH-1:0] pending_nxt;
    logic [N_CH-1:0] live_nxt;
    logic [N_CH-1:0] enabled;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   vec_idx;
    logic            vec_valid;
    logic            win_any;
    logic            ack_take;
    logic            vec_live;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rise     = ch_irq & ~irq_prev;
        w1c      = clr_we  ? clr_wdata  : '0;
        mask_nxt = mask_we ? mask_wdata : mask;
        ack_take = (state == IRQ_ASSERT) && interrupt_ack;

        vec_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            vec_onehot[k] = (vec_idx == IW'(k));
        end
        ack_bit = ack_take ? vec_onehot : '0;

        // A rising edge in the same cycle as a clear keeps the bit set.
        pending_nxt = (pending & ~(w1c | ack_bit)) | rise;

        // Whether the latched channel is still pending and enabled after this
        // cycle's CLEAR / MASK writes; used to withdraw the request early.
        live_nxt = ((pending & ~w1c) | rise) & mask_nxt;
        vec_live = |(live_nxt & vec_onehot);

        // Lowest index wins: scan downwards so the last hit is the smallest.
        enabled = pending & mask;
        win_any = |enabled;
        win_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (enabled[k]) win_idx = IW'(k);
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IRQ_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IRQ_IDLE:    if (win_any) state_nxt = IRQ_ASSERT;
            IRQ_ASSERT:  if (ack_take || !vec_live) state_nxt = IRQ_HOLDOFF;
            IRQ_HOLDOFF: state_nxt = IRQ_IDLE;
            default:     state_nxt = IRQ_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        interrupt = (state == IRQ_ASSERT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev  <= '0;
            pending   <= '0;
            mask      <= '0;
            vec_valid <= 1'b0;
            vec_idx   <= '0;
        end else begin
            irq_prev <= ch_irq;
            pending  <= pending_nxt;
            mask     <= mask_nxt;
            if (state == IRQ_IDLE && win_any) begin
                vec_valid <= 1'b1;
                vec_idx   <= win_idx;
            end else if (state == IRQ_ASSERT && state_nxt == IRQ_HOLDOFF) begin
                vec_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        vector         = '0;
        vector[IW-1:0] = vec_idx;
        vector[DW-1]   = vec_valid;
    end

endmodule

// File: rtl/io_port_hub.sv
// -----------------------------------------------------------------------------
// io_port_hub
// Port-mapped I/O hub between the KCPSM6 and N_CH peripherals. Decodes
// port_id into per-channel address windows and four hub registers, drives a
// registered read mux and registered per-channel write/read pulses, and hosts
// the maskable, prioritised interrupt controller.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   port_id           micro port address
//   out_port          micro write data
//   write_strobe      micro write strobe
//   read_strobe       micro read strobe
//   in_port           registered read data (valid 1 cycle after port_id)
//   interrupt         interrupt request; interrupt_ack acknowledges it
//   ch_sel            combinational one-hot window hit
//   ch_wr, ch_rd      1-cycle registered write/read pulses
//   ch_addr, ch_wdata offset within window and write data, latched on access
//   ch_rdata          channel read data, channel k at [k*DW +: DW]
//   ch_irq            level interrupt requests
// -----------------------------------------------------------------------------
module io_port_hub
    import io_hub_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DW       = 8,
    parameter  int AW       = 8,
    parameter  int BASE     = 'h00,
    parameter  int STRIDE   = 'h10,
    parameter  int HUB_BASE = 'hF0,
    localparam int OW       = (clog2(STRIDE) > 0) ? clog2(STRIDE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      port_id,
    input  logic [DW-1:0]      out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [DW-1:0]      in_port,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [N_CH-1:0]    ch_sel,
    output logic [N_CH-1:0]    ch_wr,
    output logic [N_CH-1:0]    ch_rd,
    output logic [OW-1:0]      ch_addr,
    output logic [DW-1:0]      ch_wdata,
    input  logic [N_CH*DW-1:0] ch_rdata,
    input  logic [N_CH-1:0]    ch_irq
);

    localparam int     SW      = clog2(STRIDE);
    localparam longint SPACE   = longint'(1) << AW;
    localparam longint WIN_END = longint'(BASE) + longint'(N_CH) * longint'(STRIDE);

    if (N_CH < 1 || N_CH > DW) begin : g_bad_nch
        $error("io_port_hub: N_CH must be in 1..DW");
    end
    if (STRIDE < 1 || (STRIDE & (STRIDE - 1)) != 0) begin : g_bad_stride
        $error("io_port_hub: STRIDE must be a power of 2");
    end
    if (WIN_END > SPACE) begin : g_bad_windows
        $error("io_port_hub: channel windows exceed the port_id space");
    end
    if (longint'(HUB_BASE) + HUB_NREGS > SPACE) begin : g_bad_hub
        $error("io_port_hub: hub registers exceed the port_id space");
    end

    logic [31:0]     pid;
    logic [31:0]     rel;
    logic [31:0]     ch_idx;
    logic [1:0]      hub_off;
    logic [OW-1:0]   ch_off;
    logic            hub_hit;
    logic            win_hit;
    logic [DW-1:0]   rd_mux;
    logic            mask_we;
    logic            clr_we;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] mask;
    logic [DW-1:0]   vector;

    // Address decode; hub registers shadow any overlapping channel window.
    always_comb begin
        pid     = 32'(port_id);
        hub_hit = (pid >= 32'(HUB_BASE)) && (pid < 32'(HUB_BASE + HUB_NREGS));
        hub_off = 2'(pid - 32'(HUB_BASE));
        rel     = pid - 32'(BASE);
        win_hit = (pid >= 32'(BASE)) && (pid < 32'(WIN_END)) && !hub_hit;
        ch_idx  = rel >> SW;
        ch_off  = OW'(rel & 32'(STRIDE - 1));

        ch_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_sel[k] = win_hit && (ch_idx == 32'(k));
        end

        mask_we = write_strobe && hub_hit && (hub_off == HUB_MASK);
        clr_we  = write_strobe && hub_hit && (hub_off == HUB_CLEAR);
    end

    // Read mux; unmapped addresses and CLEAR read as zero.
    always_comb begin
        rd_mux = '0;
        if (hub_hit) begin
            unique case (hub_off)
                HUB_PENDING: rd_mux[N_CH-1:0] = pending;
                HUB_MASK:    rd_mux[N_CH-1:0] = mask;
                HUB_VECTOR:  rd_mux           = vector;
                default:     rd_mux           = '0;
            endcase
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_sel[k]) rd_mux = ch_rdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_port  <= '0;
            ch_wr    <= '0;
            ch_rd    <= '0;
            ch_addr  <= '0;
            ch_wdata <= '0;
        end else begin
            in_port <= rd_mux;
            ch_wr   <= write_strobe ? ch_sel : '0;
            ch_rd   <= read_strobe  ? ch_sel : '0;
            if ((write_strobe || read_strobe) && win_hit) ch_addr <= ch_off;
            if (write_strobe && win_hit)                  ch_wdata <= out_port;
        end
    end

    irq_arbiter #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_irq_arbiter (
        .clk           (clk),
        .reset         (reset),
        .ch_irq        (ch_irq),
        .mask_we       (mask_we),
        .mask_wdata    (out_port[N_CH-1:0]),
        .clr_we        (clr_we),
        .clr_wdata     (out_port[N_CH-1:0]),
        .interrupt_ack (interrupt_ack),
        .pending       (pending),
        .mask          (mask),
        .vector        (vector),
        .interrupt     (interrupt)
    );

endmodule
